alu_seq: RTL



---
 rtl/alu_seq.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- sequential execute-stage ALU with valid/ready handshakes.
//
// Takes the 4-bit ALU control lines from the ALU control decoder plus two
// operands, and returns a registered result with zero/illegal flags.
// Logic, arithmetic, compare and illegal codes finish in one cycle.
// Shifts move one bit per cycle through a SHIFT state. If FAST_SHIFT_EN is
// defined, shifts instead use a single-cycle barrel shifter, and the SHIFT
// state and its counter do not exist.
//
// Configuration macro: FAST_SHIFT_EN (undefined = iterative shifter).
//
// Ports:
//   i_Clk              rising-edge clock
//   i_Rst_n            asynchronous active-low reset
//   i_Valid / o_Ready  upstream handshake (o_Ready depends on state, i_Ready)
//   i_ALUControlLines  operation code
//   i_OpA              operand A, shift source
//   i_OpB              operand B, bits [SHW-1:0] are the shift amount
//   o_Valid / i_Ready  downstream handshake
//   o_Result           registered result
//   o_Zero             registered (o_Result == 0)
//   o_Illegal          registered, code was not a defined encoding
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            i_Clk,
  input  logic            i_Rst_n,
  input  logic            i_Valid,
  output logic            o_Ready,
  input  logic [3:0]      i_ALUControlLines,
  input  logic [XLEN-1:0] i_OpA,
  input  logic [XLEN-1:0] i_OpB,
  output logic            o_Valid,
  input  logic            i_Ready,
  output logic [XLEN-1:0] o_Result,
  output logic            o_Zero,
  output logic            o_Illegal
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;

`ifdef FAST_SHIFT_EN
  typedef enum logic [0:0] {S_IDLE, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
`endif

  state_t r_state;
  state_t w_next;

  logic            r_valid;
  logic [XLEN-1:0] r_result;
  logic            r_zero;
  logic            r_illegal;

  logic signed [XLEN-1:0] w_opa_s;
  logic signed [XLEN-1:0] w_opb_s;
  logic [SHW-1:0]         w_amt;
  logic [XLEN-1:0]        w_alu_res;
  logic                   w_illegal;
  logic                   w_is_shift;
  logic                   w_sh_left;
  logic                   w_sh_arith;
  logic                   w_accept;
  logic                   w_fin;
  logic [XLEN-1:0]        w_fin_res;
  logic                   w_fin_ill;

`ifdef FAST_SHIFT_EN
  // Single-cycle barrel shift. The arithmetic right shift goes through a
  // signed copy so that >>> replicates bit XLEN-1.
  function automatic logic [XLEN-1:0] barrel_shift(
    input logic [XLEN-1:0] v,
    input logic [SHW-1:0]  amt,
    input logic            left,
    input logic            arith
  );
    logic signed [XLEN-1:0] sv;
    sv = v;
    if (left)
      return v << amt;
    else if (arith)
      return sv >>> amt;
    else
      return v >> amt;
  endfunction
`else
  logic [XLEN-1:0] r_shreg;
  logic [SHW-1:0]  r_cnt;
  logic            r_sh_left;
  logic            r_sh_arith;
  logic            w_start;
  logic            w_step;
  logic            w_iter;
  logic [XLEN-1:0] w_shreg_nxt;

  // One-bit shift step. A logical right shift fills with 0. An arithmetic
  // right shift refills the sign bit.
  function automatic logic [XLEN-1:0] shift_step(
    input logic [XLEN-1:0] v,
    input logic            left,
    input logic            arith
  );
    if (left)
      return {v[XLEN-2:0], 1'b0};
    else
      return {arith & v[XLEN-1], v[XLEN-1:1]};
  endfunction
`endif

  // Decode and single-cycle execute (combinational from the live inputs).
  // Operands only take effect on the accept cycle.
  always_comb begin
    w_opa_s    = i_OpA;
    w_opb_s    = i_OpB;
    w_amt      = i_OpB[SHW-1:0];
    w_alu_res  = '0;
    w_illegal  = 1'b0;
    w_is_shift = 1'b0;
    w_sh_left  = 1'b0;
    w_sh_arith = 1'b0;
    // An X/Z code matches no item, so it falls through to illegal.
    case (i_ALUControlLines)
      OP_ADD:  w_alu_res = i_OpA + i_OpB;
      OP_SUB:  w_alu_res = i_OpA - i_OpB;
      OP_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, (w_opa_s < w_opb_s)};
      OP_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, (i_OpA < i_OpB)};
      OP_XOR:  w_alu_res = i_OpA ^ i_OpB;
      OP_OR:   w_alu_res = i_OpA | i_OpB;
      OP_AND:  w_alu_res = i_OpA & i_OpB;
      OP_SLL: begin
        w_is_shift = 1'b1;
        w_sh_left  = 1'b1;
      end
      OP_SRL: begin
        w_is_shift = 1'b1;
      end
      OP_SRA: begin
        w_is_shift = 1'b1;
        w_sh_arith = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_is_shift) begin
`ifdef FAST_SHIFT_EN
      w_alu_res = barrel_shift(i_OpA, w_amt, w_sh_left, w_sh_arith);
`else
      // Only a zero-amount shift completes directly. Its result is OpA.
      w_alu_res = i_OpA;
`endif
    end
  end

`ifndef FAST_SHIFT_EN
  assign w_iter      = w_is_shift && (w_amt != '0);
  assign w_shreg_nxt = shift_step(r_shreg, r_sh_left, r_sh_arith);
`endif

  // Next-state and handshake logic. IDLE and DONE share the accept path,
  // so a DONE with i_Ready high can take a new operation in the same cycle.
  always_comb begin
    w_next    = r_state;
    o_Ready   = 1'b0;
    w_fin     = 1'b0;
    w_fin_res = '0;
    w_fin_ill = 1'b0;
`ifndef FAST_SHIFT_EN
    w_start   = 1'b0;
    w_step    = 1'b0;
`endif
    case (r_state)
      S_IDLE: o_Ready = 1'b1;
      S_DONE: o_Ready = i_Ready;
      default: o_Ready = 1'b0;
    endcase
    w_accept = i_Valid && o_Ready;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
`ifndef FAST_SHIFT_EN
          if (w_iter) begin
            w_next  = S_SHIFT;
            w_start = 1'b1;
          end else
`endif
          begin
            w_next    = S_DONE;
            w_fin     = 1'b1;
            w_fin_res = w_alu_res;
            w_fin_ill = w_illegal;
          end
        end else if ((r_state == S_DONE) && i_Ready) begin
          w_next = S_IDLE;
        end
      end
`ifndef FAST_SHIFT_EN
      S_SHIFT: begin
        w_step = 1'b1;
        // The final shift and the handoff to DONE happen on the same edge.
        if (r_cnt == SHW'(1)) begin
          w_next    = S_DONE;
          w_fin     = 1'b1;
          w_fin_res = w_shreg_nxt;
        end
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // Output registers. The result and flags load only on entry into DONE.
  // A DONE -> SHIFT move drops o_Valid but keeps the old result.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_valid   <= 1'b0;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_valid <= (w_next == S_DONE);
      if (w_fin) begin
        r_result  <= w_fin_res;
        r_zero    <= (w_fin_res == '0);
        r_illegal <= w_fin_ill;
      end
    end
  end

`ifndef FAST_SHIFT_EN
  // Shift counter. It is reset so that an aborted shift leaves no residue.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n)
      r_cnt <= '0;
    else if (w_start)
      r_cnt <= w_amt;
    else if (w_step)
      r_cnt <= r_cnt - SHW'(1);
  end

  // Shift datapath. It is only meaningful while in SHIFT, so it has no reset.
  always_ff @(posedge i_Clk) begin
    if (w_start) begin
      r_shreg    <= i_OpA;
      r_sh_left  <= w_sh_left;
      r_sh_arith <= w_sh_arith;
    end else if (w_step) begin
      r_shreg <= w_shreg_nxt;
    end
  end
`endif

  assign o_Valid   = r_valid;
  assign o_Result  = r_result;
  assign o_Zero    = r_zero;
  assign o_Illegal = r_illegal;

endmodule
